// File: rtl/stream_seq_checker_if.sv
// AXI-Stream handshake bundle between an upstream source and the sequence checker.
interface stream_seq_checker_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  tvalid;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tready;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/stream_seq_checker.sv
// Incrementing-byte stream sink: locks onto the sequence, counts mismatches and beats.
// Define READY_THROTTLE_EN to drive tready from a 16-bit LFSR (~75% duty) instead of constant 1.
module stream_seq_checker #(
   parameter int DATA_WIDTH   = 8,
   parameter int LOCK_COUNT   = 16,
   parameter int UNLOCK_COUNT = 4,
   parameter int ERR_WIDTH    = 16
) (
   input  logic                  clock,
   input  logic                  aresetn,
   stream_seq_checker_if.slave   s_axis,
   input  logic                  clear,
   output logic                  locked,
   output logic                  err_pulse,
   output logic [ERR_WIDTH-1:0]  err_cnt,
   output logic [31:0]           beat_cnt
);

   localparam int STREAK_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int STREAK_W   = $clog2(STREAK_MAX + 1);
   localparam logic [STREAK_W-1:0] LOCK_LAST   = STREAK_W'(LOCK_COUNT - 1);
   localparam logic [STREAK_W-1:0] UNLOCK_LAST = STREAK_W'(UNLOCK_COUNT - 1);

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                state_reg,     state_next;
   logic [STREAK_W-1:0]   streak_reg,    streak_next;
   logic [DATA_WIDTH-1:0] expected_reg,  expected_next;
   logic [ERR_WIDTH-1:0]  err_cnt_reg,   err_cnt_next;
   logic [31:0]           beat_cnt_reg,  beat_cnt_next;
   logic                  err_pulse_reg, err_pulse_next;
   logic                  tready_reg;

   logic beat;
   logic match;
   logic err_hit;

   assign beat    = s_axis.tvalid & tready_reg;
   assign match   = (s_axis.tdata == expected_reg);
   assign err_hit = beat & (state_reg == ST_LOCKED) & ~match;

   always_ff @(posedge clock) begin
      if (!aresetn) begin
         state_reg     <= ST_SEED;
         streak_reg    <= '0;
         expected_reg  <= '0;
         err_cnt_reg   <= '0;
         beat_cnt_reg  <= '0;
         err_pulse_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         streak_reg    <= streak_next;
         expected_reg  <= expected_next;
         err_cnt_reg   <= err_cnt_next;
         beat_cnt_reg  <= beat_cnt_next;
         err_pulse_reg <= err_pulse_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      streak_next = streak_reg;
      if (beat) begin
         case (state_reg)
            ST_SEED: begin
               state_next  = ST_HUNT;
               streak_next = '0;
            end
            ST_HUNT: begin
               if (!match) begin
                  streak_next = '0;
               end else if (streak_reg == LOCK_LAST) begin
                  state_next  = ST_LOCKED;
                  streak_next = '0;
               end else begin
                  streak_next = streak_reg + 1'b1;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  streak_next = '0;
               end else if (streak_reg == UNLOCK_LAST) begin
                  state_next  = ST_HUNT;
                  streak_next = '0;
               end else begin
                  streak_next = streak_reg + 1'b1;
               end
            end
            default: begin
               state_next  = ST_SEED;
               streak_next = '0;
            end
         endcase
      end
   end

   // expected follows the received byte, not the previous expectation, so one bad byte costs two errors
   always_comb begin
      expected_next  = beat ? DATA_WIDTH'(s_axis.tdata + 1'b1) : expected_reg;
      err_pulse_next = err_hit;
      err_cnt_next   = err_cnt_reg;
      if (clear)
         err_cnt_next = '0;
      else if (err_hit && (err_cnt_reg != '1))
         err_cnt_next = err_cnt_reg + 1'b1;
      beat_cnt_next = beat_cnt_reg;
      if (clear)
         beat_cnt_next = '0;
      else if (beat)
         beat_cnt_next = beat_cnt_reg + 32'd1;
   end

`ifdef READY_THROTTLE_EN
   logic [15:0] lfsr_reg;
   logic [15:0] lfsr_next;

   // Fibonacci taps 16,14,13,11 feed bit 0; remaining bits shift up
   assign lfsr_next[0] = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
   generate
      for (genvar gi = 1; gi < 16; gi++) begin : g_lfsr_shift
         assign lfsr_next[gi] = lfsr_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!aresetn) begin
         lfsr_reg   <= 16'hACE1;
         tready_reg <= 1'b0;
      end else begin
         lfsr_reg   <= lfsr_next;
         tready_reg <= lfsr_reg[0] | lfsr_reg[1];
      end
   end
`else
   always_ff @(posedge clock) begin
      if (!aresetn)
         tready_reg <= 1'b0;
      else
         tready_reg <= 1'b1;
   end
`endif

   assign s_axis.tready = tready_reg;
   assign locked        = (state_reg == ST_LOCKED);
   assign err_pulse     = err_pulse_reg;
   assign err_cnt       = err_cnt_reg;
   assign beat_cnt      = beat_cnt_reg;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Bench for stream_seq_checker: directed vector table, corner sequences, then randomized
// traffic against a behavioural model; a second instance with ERR_WIDTH=4 checks saturation.
module tb_stream_seq_checker;

   localparam int DW     = 8;
   localparam int LOCK   = 16;
   localparam int UNLOCK = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        aresetn;
   logic        clear;
   logic        locked,  err_pulse;
   logic [15:0] err_cnt;
   logic [31:0] beat_cnt;
   logic        locked4, err_pulse4;
   logic [3:0]  err_cnt4;
   logic [31:0] beat_cnt4;

   stream_seq_checker_if #(.DATA_WIDTH(DW)) s_if  ();
   stream_seq_checker_if #(.DATA_WIDTH(DW)) s4_if ();

   stream_seq_checker #(.DATA_WIDTH(DW), .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .ERR_WIDTH(16)) dut (
      .clock(clock), .aresetn(aresetn), .s_axis(s_if), .clear(clear),
      .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .beat_cnt(beat_cnt));

   stream_seq_checker #(.DATA_WIDTH(DW), .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .ERR_WIDTH(4)) dut4 (
      .clock(clock), .aresetn(aresetn), .s_axis(s4_if), .clear(clear),
      .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .beat_cnt(beat_cnt4));

   typedef struct {
      logic [7:0]  d;
      logic        exp_locked;
      logic        exp_pulse;
      logic [15:0] exp_err;
      logic [31:0] exp_beats;
   } vec_t;

   int passed = 0;
   int total  = 0;

   // behavioural model: counts runs of matches/misses against previous byte + 1
   bit         m_seeded, m_locked, m_pulse;
   logic [7:0] m_prev;
   int         m_run, m_miss;
   longint     m_errs, m_beats;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   task automatic model_reset();
      m_seeded = 0; m_locked = 0; m_pulse = 0; m_prev = '0;
      m_run = 0; m_miss = 0; m_errs = 0; m_beats = 0;
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit c, input bit rstn);
      bit rdy, beat, match;
      @(negedge clock);
      aresetn = rstn; clear = c;
      s_if.tvalid = v;  s_if.tdata = d;
      s4_if.tvalid = v; s4_if.tdata = d;
      rdy = s_if.tready;
      @(posedge clock);
      #1;
      beat = v && rdy && rstn;
      m_pulse = 0;
      if (!rstn) begin
         model_reset();
      end else begin
         if (beat) begin
            m_beats = (m_beats + 1) & 64'hFFFF_FFFF;
            if (!m_seeded) begin
               m_seeded = 1;
            end else begin
               match = (d == 8'(m_prev + 1));
               if (!m_locked) begin
                  m_run = match ? m_run + 1 : 0;
                  if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
               end else if (match) begin
                  m_miss = 0;
               end else begin
                  m_errs++; m_pulse = 1; m_miss++;
                  if (m_miss == UNLOCK) begin m_locked = 0; m_miss = 0; m_run = 0; end
               end
            end
            m_prev = d;
         end
         if (c) begin m_errs = 0; m_beats = 0; end
      end
      chk("locked",    locked,    m_locked);
      chk("err_pulse", err_pulse, m_pulse);
      chk("err_cnt",   err_cnt,   (m_errs > 65535) ? 65535 : m_errs);
      chk("beat_cnt",  beat_cnt,  m_beats);
      chk("locked4",   locked4,   m_locked);
      chk("err_cnt4",  err_cnt4,  (m_errs > 15) ? 15 : m_errs);
`ifndef READY_THROTTLE_EN
      chk("tready", s_if.tready, rstn);
`else
      if (!rstn) chk("tready_rst", s_if.tready, 0);
`endif
      if (beat)
         $display("beat d=%02h clr=%0d locked=%0d pulse=%0d err=%0d err4=%0d beats=%0d",
                  d, c, locked, err_pulse, err_cnt, err_cnt4, beat_cnt);
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [0:261];
      logic [7:0] e, d;
      bit         v, c, r, src_valid;
      logic [7:0] src_cnt;
      int         hs, rdy_hi, rdy_lo, ncyc;

      for (int i = 0; i < 262; i++) begin
         tbl[i].d          = (i == 66) ? 8'h99 : 8'(i);
         tbl[i].exp_locked = (i >= 16);
         tbl[i].exp_pulse  = (i == 66 || i == 67);
         tbl[i].exp_err    = (i < 66) ? 16'd0 : (i == 66) ? 16'd1 : 16'd2;
         tbl[i].exp_beats  = 32'(i + 1);
      end

      aresetn = 0; clear = 0;
      s_if.tvalid = 0; s_if.tdata = 0; s4_if.tvalid = 0; s4_if.tdata = 0;
      model_reset();

      // reset held with tvalid high
      for (int k = 0; k < 5; k++) begin
         step(1, 8'h00, 0, 0);
         chk("rst_tready", s_if.tready, 0);
         chk("rst_beat_cnt", beat_cnt, 0);
      end
      step(0, 8'h00, 0, 1);
      chk("release_tready", s_if.tready, 1);
      chk("release_locked", locked, 0);

      // contiguous lock-up, in-lock corruption, wrap 0xFF->0x00
      for (int i = 0; i < 262; i++) begin
         step(1, tbl[i].d, 0, 1);
         chk($sformatf("tbl%0d_locked", i), locked,    tbl[i].exp_locked);
         chk($sformatf("tbl%0d_pulse", i),  err_pulse, tbl[i].exp_pulse);
         chk($sformatf("tbl%0d_err", i),    err_cnt,   tbl[i].exp_err);
         chk($sformatf("tbl%0d_beats", i),  beat_cnt,  tbl[i].exp_beats);
      end

      // gap does not disturb lock
      for (int k = 0; k < 7; k++) step(0, 8'hEE, 0, 1);
      chk("gap_locked", locked, 1);

      // four wrong bytes unlock on the fourth
      for (int k = 0; k < 4; k++) begin
         e = 8'(m_prev + 1);
         d = 8'(e + 8'($urandom_range(1, 255)));
         step(1, d, 0, 1);
         chk($sformatf("unlock%0d_locked", k), locked, (k < 3));
         chk($sformatf("unlock%0d_pulse", k), err_pulse, 1);
      end
      chk("unlock_err", err_cnt, 6);
      for (int k = 0; k < 16; k++) begin
         step(1, 8'(m_prev + 1), 0, 1);
         chk($sformatf("relock%0d", k), locked, (k == 15));
      end

      // saturation of the narrow counter: 10 corrupted bytes = 20 errors
      step(0, 8'h00, 1, 1);
      chk("clr_err", err_cnt, 0);
      for (int k = 0; k < 10; k++) begin
         e = 8'(m_prev + 1);
         step(1, e ^ 8'h55, 0, 1);
         step(1, 8'(e + 1), 0, 1);
         step(1, 8'(e + 2), 0, 1);
      end
      chk("sat_err4", err_cnt4, 15);
      chk("sat_err16", err_cnt, 20);
      chk("sat_locked", locked, 1);

      // clear coinciding with a mismatching beat
      e = 8'(m_prev + 1);
      step(1, e ^ 8'h0F, 1, 1);
      chk("clrmis_pulse", err_pulse, 1);
      chk("clrmis_err", err_cnt, 0);
      chk("clrmis_beats", beat_cnt, 0);
      step(1, 8'(e + 1), 0, 1);
      step(1, 8'(e + 2), 0, 1);
      step(0, 8'h00, 1, 1);
      chk("clr_err_final", err_cnt, 0);
      chk("clr_beats_final", beat_cnt, 0);
      chk("clr_locked", locked, 1);

      // randomized traffic, occasional clear and mid-stream reset
      for (int k = 0; k < 1500; k++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 49) == 0);
         r = ($urandom_range(0, 299) != 0);
         d = ($urandom_range(0, 99) < 85) ? 8'(m_prev + 1) : 8'($urandom);
         step(v, d, c, r);
      end

      // well-behaved counter source from a fresh reset
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      src_cnt = 8'($urandom); src_valid = 0; hs = 0; rdy_hi = 0; rdy_lo = 0;
`ifdef READY_THROTTLE_EN
      ncyc = 10000;
`else
      ncyc = 2000;
`endif
      for (int k = 0; k < ncyc; k++) begin
         bit pre_rdy;
         if (!src_valid) src_valid = ($urandom_range(0, 9) != 0);
         pre_rdy = s_if.tready;
         step(src_valid, src_cnt, 0, 1);
         if (src_valid && pre_rdy) begin
            hs++; src_cnt = 8'(src_cnt + 1); src_valid = 0;
         end
         if (s_if.tready) rdy_hi++; else rdy_lo++;
      end
      chk("src_locked", locked, 1);
      chk("src_err", err_cnt, 0);
      chk("src_beats", beat_cnt, hs);
`ifdef READY_THROTTLE_EN
      chk("src_tready_toggles", (rdy_hi > 0) && (rdy_lo > 0), 1);
`else
      chk("src_tready_high", rdy_lo, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
